// File: rtl/bf_path_walker_if.sv
// Stream and RAM-port bundle for bf_path_walker.
// master: the walker itself; slave: the surrounding system (RAM, VGA stage, control).
interface bf_path_walker_if #(
  parameter int unsigned NODE_W = 5
);
  logic              start;
  logic [NODE_W-1:0] src_node;
  logic [NODE_W-1:0] dst_node;
  logic [NODE_W-1:0] pred_raddr;
  logic [NODE_W:0]   pred_rdata;
  logic              busy;
  logic              done;
  logic              unreachable;
  logic              loop_err;
  logic [NODE_W-1:0] path_node;
  logic              path_valid;
  logic              path_ready;
  logic              path_last;
  logic [NODE_W:0]   path_len;

  modport master (
    input  start, src_node, dst_node, pred_rdata, path_ready,
    output pred_raddr, busy, done, unreachable, loop_err,
    output path_node, path_valid, path_last, path_len
  );

  modport slave (
    output start, src_node, dst_node, pred_rdata, path_ready,
    input  pred_raddr, busy, done, unreachable, loop_err,
    input  path_node, path_valid, path_last, path_len
  );
endinterface

// File: rtl/bf_path_walker.sv
// Walks Bellman-Ford predecessor links from dst back to src, stacks the nodes and
// replays them source-first over a valid/ready stream.
// Optional macro PATHW_LOOP_GUARD_EN: abort with loop_err when the chain exceeds NUM_NODES.
module bf_path_walker #(
  parameter int unsigned NODE_W    = 5,
  parameter int unsigned NUM_NODES = 32
) (
  input  logic             clk,
  input  logic             rst,
  bf_path_walker_if.master bus
);
  typedef logic [NODE_W-1:0] node_t;
  typedef logic [NODE_W:0]   cnt_t;

  localparam cnt_t Full = cnt_t'(NUM_NODES);

  typedef enum logic [2:0] {StIdle, StWalk, StFetch, StEmit, StFin} state_e;

  state_e state_q, state_d;
  node_t  stack_q [NUM_NODES];
  node_t  stack_d [NUM_NODES];
  cnt_t   depth_q, depth_d;
  node_t  cur_q, cur_d;
  node_t  src_q, src_d;
  node_t  raddr_q, raddr_d;
  cnt_t   len_q, len_d;
  logic   unreach_q, unreach_d;
`ifdef PATHW_LOOP_GUARD_EN
  logic   loop_q, loop_d;
`endif

  node_t wr_idx;
  node_t top_idx;

  // Full stack keeps overwriting its top slot instead of running off the end
  assign wr_idx  = (depth_q < Full) ? node_t'(depth_q) : node_t'(NUM_NODES - 1);
  assign top_idx = node_t'(depth_q - cnt_t'(1));

  // Next-state, stack and flag updates
  always_comb begin
    state_d   = state_q;
    stack_d   = stack_q;
    depth_d   = depth_q;
    cur_d     = cur_q;
    src_d     = src_q;
    raddr_d   = raddr_q;
    len_d     = len_q;
    unreach_d = unreach_q;
`ifdef PATHW_LOOP_GUARD_EN
    loop_d    = loop_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          src_d     = bus.src_node;
          cur_d     = bus.dst_node;
          depth_d   = '0;
          len_d     = '0;
          unreach_d = 1'b0;
`ifdef PATHW_LOOP_GUARD_EN
          loop_d    = 1'b0;
`endif
          state_d   = StWalk;
        end
      end
      StWalk: begin
        if (cur_q == src_q) begin
          stack_d[wr_idx] = cur_q;
          depth_d = (depth_q == Full) ? Full : depth_q + cnt_t'(1);
          len_d   = (depth_q == Full) ? Full : depth_q + cnt_t'(1);
          state_d = StEmit;
`ifdef PATHW_LOOP_GUARD_EN
        end else if (depth_q == Full) begin
          loop_d  = 1'b1;
          state_d = StFin;
`endif
        end else begin
          stack_d[wr_idx] = cur_q;
          depth_d = (depth_q == Full) ? Full : depth_q + cnt_t'(1);
          raddr_d = cur_q;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (!bus.pred_rdata[NODE_W]) begin
          unreach_d = 1'b1;
          state_d   = StFin;
        end else begin
          cur_d   = bus.pred_rdata[NODE_W-1:0];
          state_d = StWalk;
        end
      end
      StEmit: begin
        if (bus.path_ready) begin
          depth_d = depth_q - cnt_t'(1);
          if (depth_q == cnt_t'(1)) state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      for (int i = 0; i < NUM_NODES; i++) stack_q[i] <= '0;
      depth_q   <= '0;
      cur_q     <= '0;
      src_q     <= '0;
      raddr_q   <= '0;
      len_q     <= '0;
      unreach_q <= 1'b0;
`ifdef PATHW_LOOP_GUARD_EN
      loop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stack_q   <= stack_d;
      depth_q   <= depth_d;
      cur_q     <= cur_d;
      src_q     <= src_d;
      raddr_q   <= raddr_d;
      len_q     <= len_d;
      unreach_q <= unreach_d;
`ifdef PATHW_LOOP_GUARD_EN
      loop_q    <= loop_d;
`endif
    end
  end

  // The RAM address follows cur only on a fetching WALK and otherwise holds
  assign bus.pred_raddr  = raddr_d;
  assign bus.busy        = (state_q == StWalk) || (state_q == StFetch) || (state_q == StEmit);
  assign bus.done        = (state_q == StFin);
  assign bus.unreachable = unreach_q;
`ifdef PATHW_LOOP_GUARD_EN
  assign bus.loop_err    = loop_q;
`else
  assign bus.loop_err    = 1'b0;
`endif
  assign bus.path_valid  = (state_q == StEmit);
  assign bus.path_node   = (state_q == StEmit) ? stack_q[top_idx] : '0;
  assign bus.path_last   = (state_q == StEmit) && (depth_q == cnt_t'(1));
  assign bus.path_len    = len_q;
endmodule

// File: tb/tb_bf_path_walker.sv
// Scoreboard bench for bf_path_walker: expected path elements are queued at start and
// popped on every stream handshake. Inputs driven and outputs sampled on negedge.
module tb_bf_path_walker;
  localparam int unsigned NodeW    = 5;
  localparam int unsigned NumNodes = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bf_path_walker_if #(.NODE_W(NodeW)) bus ();

  bf_path_walker #(.NODE_W(NodeW), .NUM_NODES(NumNodes)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Predecessor RAM model, 1-cycle synchronous read
  logic [NodeW:0] mem [NumNodes];
  always @(posedge clk) bus.pred_rdata <= mem[bus.pred_raddr];

  typedef logic [NodeW:0] exp_t; // {node, last}
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic clear_mem();
    for (int i = 0; i < NumNodes; i++) mem[i] = '0;
  endtask

  task automatic load_chain();
    clear_mem();
    mem[7] = {1'b1, 5'd3};
    mem[3] = {1'b1, 5'd1};
    sb_q.delete();
    sb_q.push_back({5'd1, 1'b0});
    sb_q.push_back({5'd3, 1'b0});
    sb_q.push_back({5'd7, 1'b1});
  endtask

  // Called at a negedge; returns at the negedge after start is accepted
  task automatic do_start(input logic [NodeW-1:0] s, input logic [NodeW-1:0] d);
    bus.src_node = s;
    bus.dst_node = d;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.src_node = '0;
    bus.dst_node = '0;
    bus.path_ready = 1'b0;
    clear_mem();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.unreachable, bus.loop_err, bus.path_valid, bus.path_last,
         bus.path_node, bus.path_len, bus.pred_raddr} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got busy=%b done=%b unr=%b loop=%b v=%b last=%b node=%0d len=%0d raddr=%0d, want all 0",
               bus.busy, bus.done, bus.unreachable, bus.loop_err, bus.path_valid,
               bus.path_last, bus.path_node, bus.path_len, bus.pred_raddr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_chain();
    int first_valid = -1;
    int done_at = -1;
    exp_t e;
    load_chain();
    bus.path_ready = 1'b1;
    do_start(5'd1, 5'd7);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL chain_busy: got %b want 1", bus.busy);
    end
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      if (bus.path_valid === 1'b1) begin
        if (first_valid < 0) begin
          first_valid = c;
          vectors++;
          if (bus.path_len !== 6'd3) begin
            miscompares++;
            $display("FAIL chain_len: got %0d want 3", bus.path_len);
          end
        end
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL chain_extra: got node %0d want no element", bus.path_node);
        end else begin
          e = sb_q.pop_front();
          if ({bus.path_node, bus.path_last} !== e) begin
            miscompares++;
            $display("FAIL chain_elem: got node=%0d last=%b want node=%0d last=%b",
                     bus.path_node, bus.path_last, e[NodeW:1], e[0]);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_at = c;
        vectors++;
        if ({bus.busy, bus.unreachable, bus.loop_err} !== 3'b000) begin
          miscompares++;
          $display("FAIL chain_done_flags: got busy/unr/loop=%b want 000",
                   {bus.busy, bus.unreachable, bus.loop_err});
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (first_valid != 5) begin
      miscompares++;
      $display("FAIL chain_emit_cycle: got %0d want 5", first_valid);
    end
    vectors++;
    if (done_at != 8) begin
      miscompares++;
      $display("FAIL chain_done_cycle: got %0d want 8", done_at);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL chain_missing: got %0d left want 0", sb_q.size());
    end
    vectors++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL chain_after_done: got done/busy=%b want 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_src_eq_dst();
    logic [NodeW-1:0] raddr0;
    int moved = 0;
    int elems = 0;
    int done_at = -1;
    exp_t e;
    clear_mem();
    sb_q.delete();
    sb_q.push_back({5'd5, 1'b1});
    bus.path_ready = 1'b1;
    raddr0 = bus.pred_raddr;
    do_start(5'd5, 5'd5);
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      if (bus.pred_raddr !== raddr0) moved++;
      if (bus.path_valid === 1'b1) begin
        elems++;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL same_extra: got node %0d want none", bus.path_node);
        end else begin
          e = sb_q.pop_front();
          if ({bus.path_node, bus.path_last} !== e || bus.path_len !== 6'd1) begin
            miscompares++;
            $display("FAIL same_elem: got node=%0d last=%b len=%0d want node=5 last=1 len=1",
                     bus.path_node, bus.path_last, bus.path_len);
          end
        end
      end
      if (bus.done === 1'b1) done_at = c;
      @(negedge clk);
    end
    vectors++;
    if (moved != 0) begin
      miscompares++;
      $display("FAIL same_raddr: got %0d changed cycles want 0", moved);
    end
    vectors++;
    if (elems != 1 || done_at != 2) begin
      miscompares++;
      $display("FAIL same_shape: got elems=%0d done_at=%0d want 1 and 2", elems, done_at);
    end
  endtask

  task automatic test_unreachable();
    int valids = 0;
    int done_at = -1;
    clear_mem();
    mem[12] = {1'b1, 5'd9};
    bus.path_ready = 1'b1;
    do_start(5'd1, 5'd12);
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      if (bus.path_valid === 1'b1) valids++;
      if (bus.done === 1'b1) begin
        done_at = c;
        vectors++;
        if ({bus.unreachable, bus.loop_err, bus.busy} !== 3'b100) begin
          miscompares++;
          $display("FAIL unr_flags: got unr/loop/busy=%b want 100",
                   {bus.unreachable, bus.loop_err, bus.busy});
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (valids != 0 || done_at != 4) begin
      miscompares++;
      $display("FAIL unr_shape: got valids=%0d done_at=%0d want 0 and 4", valids, done_at);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.unreachable, bus.done, bus.path_len} !== {1'b1, 1'b0, 6'd0}) begin
      miscompares++;
      $display("FAIL unr_sticky: got unr=%b done=%b len=%0d want 1 0 0",
               bus.unreachable, bus.done, bus.path_len);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int done_at = -1;
    logic held = 1'b0;
    exp_t held_val = '0;
    exp_t e;
    load_chain();
    do_start(5'd1, 5'd7);
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      bus.path_ready = (c % 2 == 0);
      if (bus.path_valid === 1'b1 && held) begin
        vectors++;
        if ({bus.path_node, bus.path_last} !== held_val) begin
          miscompares++;
          $display("FAIL bp_hold: got node=%0d last=%b want node=%0d last=%b",
                   bus.path_node, bus.path_last, held_val[NodeW:1], held_val[0]);
        end
      end
      held = 1'b0;
      if (bus.path_valid === 1'b1 && bus.path_ready) begin
        hs++;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: got node %0d want none", bus.path_node);
        end else begin
          e = sb_q.pop_front();
          if ({bus.path_node, bus.path_last} !== e) begin
            miscompares++;
            $display("FAIL bp_elem: got node=%0d last=%b want node=%0d last=%b",
                     bus.path_node, bus.path_last, e[NodeW:1], e[0]);
          end
        end
      end else if (bus.path_valid === 1'b1) begin
        held = 1'b1;
        held_val = {bus.path_node, bus.path_last};
      end
      if (bus.done === 1'b1) done_at = c;
      @(negedge clk);
    end
    bus.path_ready = 1'b1;
    vectors++;
    if (hs != 3 || done_at < 0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: got hs=%0d done_at=%0d left=%0d want 3 >=0 0",
               hs, done_at, sb_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int done_at = -1;
    exp_t e;
    load_chain();
    bus.path_ready = 1'b1;
    do_start(5'd1, 5'd7);
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      bus.start = (c == 1);
      bus.src_node = 5'd5;
      bus.dst_node = 5'd5;
      if (bus.path_valid === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL ign_extra: got node %0d want none", bus.path_node);
        end else begin
          e = sb_q.pop_front();
          if ({bus.path_node, bus.path_last} !== e) begin
            miscompares++;
            $display("FAIL ign_elem: got node=%0d last=%b want node=%0d last=%b",
                     bus.path_node, bus.path_last, e[NodeW:1], e[0]);
          end
        end
      end
      if (bus.done === 1'b1) done_at = c;
      @(negedge clk);
    end
    bus.start = 1'b0;
    vectors++;
    if (done_at != 8 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL ign_shape: got done_at=%0d left=%0d want 8 0", done_at, sb_q.size());
    end
  endtask

`ifdef PATHW_LOOP_GUARD_EN
  task automatic test_loop();
    int valids = 0;
    int done_at = -1;
    clear_mem();
    mem[4] = {1'b1, 5'd6};
    mem[6] = {1'b1, 5'd4};
    bus.path_ready = 1'b1;
    do_start(5'd1, 5'd4);
    for (int c = 0; c < 120 && done_at < 0; c++) begin
      bus.start = (c == 10);
      if (bus.path_valid === 1'b1) valids++;
      if (bus.done === 1'b1) begin
        done_at = c;
        vectors++;
        if ({bus.loop_err, bus.unreachable} !== 2'b10) begin
          miscompares++;
          $display("FAIL loop_flags: got loop/unr=%b want 10", {bus.loop_err, bus.unreachable});
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    vectors++;
    if (valids != 0 || done_at != 65) begin
      miscompares++;
      $display("FAIL loop_shape: got valids=%0d done_at=%0d want 0 65", valids, done_at);
    end
  endtask
`endif

  task automatic test_reset_mid_emit();
    int seen = 0;
    load_chain();
    bus.path_ready = 1'b1;
    do_start(5'd1, 5'd7);
    for (int c = 0; c < 40 && seen < 2; c++) begin
      if (bus.path_valid === 1'b1) seen++;
      if (seen < 2) @(negedge clk);
    end
    vectors++;
    if (seen != 2) begin
      miscompares++;
      $display("FAIL midrst_reach: got %0d valid cycles want 2", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.unreachable, bus.loop_err, bus.path_valid, bus.path_last,
         bus.path_node, bus.path_len, bus.pred_raddr} !== '0) begin
      miscompares++;
      $display("FAIL midrst_values: got busy=%b done=%b v=%b last=%b node=%0d len=%0d raddr=%0d, want all 0",
               bus.busy, bus.done, bus.path_valid, bus.path_last, bus.path_node,
               bus.path_len, bus.pred_raddr);
    end
    rst = 1'b0;
    @(negedge clk);
    test_chain();
  endtask

  initial begin
    test_reset();
    test_chain();
    test_src_eq_dst();
    test_unreachable();
    test_backpressure();
    test_start_ignored();
`ifdef PATHW_LOOP_GUARD_EN
    test_loop();
`endif
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
